hamming74_decoder: RTL

//  Receive-side counterpart of the Hamming(7,4) encoder: accepts 7-bit codewords, computes the syndrome,

---
 rtl/hamming74_decoder.sv | 102 ++++++++++
 1 files changed

// File: rtl/hamming74_decoder.sv
// rtl/hamming74_decoder.sv - Hamming(7,4) single-error-correcting decoder, two-stage valid/ready pipeline
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   in_valid/in_ready        input handshake for in_code
//   in_code[6:0]             received codeword {d7,d6,d5,p4,d3,p2,p1}, bit0 = p1
//   out_valid/out_ready      output handshake
//   out_data[3:0]            corrected {d7,d6,d5,d3}
//   out_syndrome[2:0]        {s4,s2,s1} of the received word, 0 = clean
//   out_corrected            syndrome was nonzero and one bit was flipped back
//   cnt_clr                  synchronous clear of err_count (wins over increment)
//   err_count[CNT_W-1:0]     saturating count of delivered corrected words
//
// Double-bit errors produce a nonzero syndrome and are miscorrected; they are
// not distinguishable from single-bit errors with this code.

module hamming74_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic             out_corrected,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_count
);

    logic       s1_valid;
    logic [6:0] s1_code;
    logic [2:0] s1_syn;
    logic       s2_valid;
    logic       adv1;
    logic       adv2;
    logic [2:0] syn_in;
    logic [6:0] fixed_code;

    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;
    assign out_valid = s2_valid;

    // Each syndrome bit covers the positions whose 1-based index has that bit set.
    assign syn_in = {in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6],
                     in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6],
                     in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6]};

    // The syndrome is the 1-based position of the flipped bit.
    always_comb begin
        fixed_code = s1_code;
        if (s1_syn != 3'd0) begin
            fixed_code = s1_code ^ (7'd1 << (s1_syn - 3'd1));
        end
    end

    // Stage 1: register the received word and its syndrome.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_code  <= 7'd0;
            s1_syn   <= 3'd0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= in_code;
                s1_syn  <= syn_in;
            end
        end
    end

    // Stage 2: corrected data. Fields load only when a valid word moves in,
    // so a stalled output keeps its value.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid      <= 1'b0;
            out_data      <= 4'd0;
            out_syndrome  <= 3'd0;
            out_corrected <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data      <= {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
                out_syndrome  <= s1_syn;
                out_corrected <= (s1_syn != 3'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            err_count <= '0;
        end else if (out_valid && out_ready && out_corrected && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule
